// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Brief    : Opcode constants, control-bundle layout and rs-usage helpers
// Revision : 1.0
// ============================================================================
package id_ex_stage_pkg;

    localparam logic [6:0] c_opc_empty = 7'b0000000;
    localparam logic [6:0] c_opc_r     = 7'b0110011;
    localparam logic [6:0] c_opc_i     = 7'b0000011;  // loads
    localparam logic [6:0] c_opc_s     = 7'b0100011;
    localparam logic [6:0] c_opc_b     = 7'b1100011;

    localparam int c_wb_w     = 2;
    localparam int c_m_w      = 3;
    localparam int c_ex_w     = 3;
    localparam int c_funct_w  = 4;
    localparam int c_m_mem_rd = 0;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == c_opc_r) || (opc == c_opc_i) ||
               (opc == c_opc_s) || (opc == c_opc_b);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == c_opc_r) || (opc == c_opc_s) || (opc == c_opc_b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Brief    : ID-side inputs and EX-side outputs of the ID/EX pipeline register
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [6:0]            id_opcode_i;
    logic [c_wb_w-1:0]     id_wb_i;
    logic [c_m_w-1:0]      id_m_i;
    logic [c_ex_w-1:0]     id_ex_i;
    logic [XLEN-1:0]       id_pc_i;
    logic [XLEN-1:0]       id_rs1_data_i;
    logic [XLEN-1:0]       id_rs2_data_i;
    logic [XLEN-1:0]       id_imm_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic [c_funct_w-1:0]  id_funct_i;
    logic                  flush_i;
    logic                  hold_i;

    logic                  stall_o;
    logic                  ex_valid_o;
    logic [c_wb_w-1:0]     ex_wb_o;
    logic [c_m_w-1:0]      ex_m_o;
    logic [c_ex_w-1:0]     ex_ex_o;
    logic [XLEN-1:0]       ex_pc_o;
    logic [XLEN-1:0]       ex_rs1_data_o;
    logic [XLEN-1:0]       ex_rs2_data_o;
    logic [XLEN-1:0]       ex_imm_o;
    logic [REG_ADDR_W-1:0] ex_rs1_o;
    logic [REG_ADDR_W-1:0] ex_rs2_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic [c_funct_w-1:0]  ex_funct_o;
    logic [CNT_W-1:0]      bubble_cnt_o;

    modport master (
        output id_opcode_i, id_wb_i, id_m_i, id_ex_i, id_pc_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_funct_i,
               flush_i, hold_i,
        input  stall_o, ex_valid_o, ex_wb_o, ex_m_o, ex_ex_o, ex_pc_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
               ex_rd_o, ex_funct_o, bubble_cnt_o
    );

    modport slave (
        input  id_opcode_i, id_wb_i, id_m_i, id_ex_i, id_pc_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i, id_funct_i,
               flush_i, hold_i,
        output stall_o, ex_valid_o, ex_wb_o, ex_m_o, ex_ex_o, ex_pc_o,
               ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
               ex_rd_o, ex_funct_o, bubble_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_hazard_detect
// Brief    : Load-use hazard between the ID instruction and the load in EX
// Revision : 1.0
// ============================================================================
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [6:0]            i_opcode,
    input  wire logic [REG_ADDR_W-1:0] i_rs1,
    input  wire logic [REG_ADDR_W-1:0] i_rs2,
    input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
    input  wire logic                  i_ex_mem_read,
    input  wire logic                  i_ex_valid,
    output logic                       o_lu
);
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = uses_rs1(i_opcode) && (i_ex_rd == i_rs1);
    assign w_hit_rs2 = uses_rs2(i_opcode) && (i_ex_rd == i_rs2);

    // x0 is never written, so a load to x0 cannot create a dependence
    assign o_lu = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                  (w_hit_rs1 || w_hit_rs2);
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use bubble insertion,
//            branch flush, external hold and saturating bubble counter
// Revision : 1.0
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    id_ex_stage_if.slave  bus
);
    logic                  r_valid;
    logic [c_wb_w-1:0]     r_wb;
    logic [c_m_w-1:0]      r_m;
    logic [c_ex_w-1:0]     r_ex;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [XLEN-1:0]       r_imm;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [c_funct_w-1:0]  r_funct;
    logic [CNT_W-1:0]      r_bubble_cnt;
    logic                  w_lu;

    id_ex_stage_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_opcode      (bus.id_opcode_i),
        .i_rs1         (bus.id_rs1_i),
        .i_rs2         (bus.id_rs2_i),
        .i_ex_rd       (r_rd),
        .i_ex_mem_read (r_m[c_m_mem_rd]),
        .i_ex_valid    (r_valid),
        .o_lu          (w_lu)
    );

    // A flush kills the ID instruction, so the front end must not be held
    assign bus.stall_o = !bus.flush_i && (bus.hold_i || w_lu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_wb         <= '0;
            r_m          <= '0;
            r_ex         <= '0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_funct      <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.flush_i || (!bus.hold_i && w_lu)) begin
            r_valid    <= 1'b0;
            r_wb       <= '0;
            r_m        <= '0;
            r_ex       <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct    <= '0;
            if (!bus.flush_i && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (!bus.hold_i) begin
            r_valid    <= (bus.id_opcode_i != c_opc_empty);
            r_wb       <= bus.id_wb_i;
            r_m        <= bus.id_m_i;
            r_ex       <= bus.id_ex_i;
            r_pc       <= bus.id_pc_i;
            r_rs1_data <= bus.id_rs1_data_i;
            r_rs2_data <= bus.id_rs2_data_i;
            r_imm      <= bus.id_imm_i;
            r_rs1      <= bus.id_rs1_i;
            r_rs2      <= bus.id_rs2_i;
            r_rd       <= bus.id_rd_i;
            r_funct    <= bus.id_funct_i;
        end
    end

    assign bus.ex_valid_o    = r_valid;
    assign bus.ex_wb_o       = r_wb;
    assign bus.ex_m_o        = r_m;
    assign bus.ex_ex_o       = r_ex;
    assign bus.ex_pc_o       = r_pc;
    assign bus.ex_rs1_data_o = r_rs1_data;
    assign bus.ex_rs2_data_o = r_rs2_data;
    assign bus.ex_imm_o      = r_imm;
    assign bus.ex_rs1_o      = r_rs1;
    assign bus.ex_rs2_o      = r_rs2;
    assign bus.ex_rd_o       = r_rd;
    assign bus.ex_funct_o    = r_funct;
    assign bus.bubble_cnt_o  = r_bubble_cnt;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage: directed hazard cases + random
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_EMPTY = 7'b0000000;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [2:0]  ex;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
    } ex_t;

    typedef struct packed {
        logic [6:0]  op;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [2:0]  ex;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
    } id_t;

    typedef struct {
        logic stall;
        ex_t  st;
        int   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    ex_t  m_st;
    int   m_cnt;
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_stall = 1'b0;

    function automatic ex_t dut_state();
        ex_t s;
        s = {bus.ex_valid_o, bus.ex_wb_o, bus.ex_m_o, bus.ex_ex_o, bus.ex_pc_o,
             bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o, bus.ex_rs1_o,
             bus.ex_rs2_o, bus.ex_rd_o, bus.ex_funct_o};
        return s;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: which source registers an instruction class actually reads
    function automatic logic reads_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_LD, OP_S, OP_B};
    endfunction
    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic id_t mk(input logic [6:0] op, input logic [1:0] wb, input logic [2:0] m,
                               input logic [2:0] ex, input int rs1, input int rs2, input int rd,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        id_t i;
        i.op = op; i.wb = wb; i.m = m; i.ex = ex;
        i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0]; i.rd = rd[4:0];
        i.rs1d = d1; i.rs2d = d2; i.imm = imm;
        i.pc = $urandom & 32'hffff_fffc;
        i.funct = 4'($urandom_range(0, 15));
        return i;
    endfunction

    task automatic issue(input id_t id, input logic fl, input logic hd);
        exp_t e;
        logic dep;
        @(negedge clk);
        bus.id_opcode_i   = id.op;
        bus.id_wb_i       = id.wb;
        bus.id_m_i        = id.m;
        bus.id_ex_i       = id.ex;
        bus.id_pc_i       = id.pc;
        bus.id_rs1_data_i = id.rs1d;
        bus.id_rs2_data_i = id.rs2d;
        bus.id_imm_i      = id.imm;
        bus.id_rs1_i      = id.rs1;
        bus.id_rs2_i      = id.rs2;
        bus.id_rd_i       = id.rd;
        bus.id_funct_i    = id.funct;
        bus.flush_i       = fl;
        bus.hold_i        = hd;
        // A real load sitting in EX whose destination the ID instruction reads
        dep = m_st.valid && m_st.m[0] && (m_st.rd != 0) &&
              ((reads_rs1(id.op) && m_st.rd == id.rs1) ||
               (reads_rs2(id.op) && m_st.rd == id.rs2));
        e.stall = !fl && (hd || dep);
        if (fl) begin
            m_st = '0;
        end else if (!hd) begin
            if (dep) begin
                m_st  = '0;
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_st = {id.op != OP_EMPTY, id.wb, id.m, id.ex, id.pc, id.rs1d,
                        id.rs2d, id.imm, id.rs1, id.rs2, id.rd, id.funct};
            end
        end
        e.st = m_st;
        e.cnt = m_cnt;
        last_stall = e.stall;
        sb.push_back(e);
    endtask

    // Monitor: stall is checked before the edge, registered state after it
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            #1;
            check("stall", 160'(bus.stall_o), 160'(e.stall));
            @(posedge clk);
            #1;
            check("ex_valid", 160'(bus.ex_valid_o), 160'(e.st.valid));
            check("ex_bundle", 160'(dut_state()), 160'(e.st));
            check("bubble_cnt", 160'(bus.bubble_cnt_o), 160'(e.cnt));
        end
    end

    task automatic drain();
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
    endtask

    task automatic async_reset_check();
        drain();
        rst_n = 1'b0;
        #1;
        check("reset_state", 160'(dut_state()), 160'd0);
        check("reset_cnt", 160'(bus.bubble_cnt_o), 160'd0);
        m_st = '0;
        m_cnt = 0;
        last_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        id_t add3, lw5, add65, lw0, add60, lw7, sw5, cur;
        logic [6:0] ops [7];
        ops[0] = OP_EMPTY; ops[1] = OP_R; ops[2] = OP_LD; ops[3] = OP_S;
        ops[4] = OP_B; ops[5] = OP_ALUI; ops[6] = OP_JAL;

        m_st = '0;
        m_cnt = 0;
        bus.id_opcode_i = '0; bus.id_wb_i = '0; bus.id_m_i = '0; bus.id_ex_i = '0;
        bus.id_pc_i = '0; bus.id_rs1_data_i = '0; bus.id_rs2_data_i = '0;
        bus.id_imm_i = '0; bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_rd_i = '0;
        bus.id_funct_i = '0; bus.flush_i = 1'b0; bus.hold_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("por_state", 160'(dut_state()), 160'd0);
        check("por_cnt", 160'(bus.bubble_cnt_o), 160'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add3  = mk(OP_R,  2'b10, 3'b000, 3'b010, 1, 2, 3, 32'd5, 32'd7, 32'd0);
        lw5   = mk(OP_LD, 2'b11, 3'b001, 3'b100, 1, 0, 5, 32'h40, 32'd0, 32'd8);
        add65 = mk(OP_R,  2'b10, 3'b000, 3'b010, 5, 1, 6, 32'd9, 32'd3, 32'd0);
        lw0   = mk(OP_LD, 2'b11, 3'b001, 3'b100, 1, 0, 0, 32'h44, 32'd0, 32'd4);
        add60 = mk(OP_R,  2'b10, 3'b000, 3'b010, 0, 1, 6, 32'd0, 32'd3, 32'd0);
        lw7   = mk(OP_LD, 2'b11, 3'b001, 3'b100, 1, 5, 7, 32'h48, 32'd0, 32'd0);
        sw5   = mk(OP_S,  2'b00, 3'b010, 3'b100, 1, 5, 0, 32'h48, 32'h55, 32'd0);

        issue(add3, 0, 0);
        issue(lw5, 0, 0);
        issue(add65, 0, 0);
        issue(add65, 0, 0);
        drain();
        check("one_bubble_cnt", 160'(bus.bubble_cnt_o), 160'd1);

        issue(lw0, 0, 0);  issue(add60, 0, 0);
        issue(lw5, 0, 0);  issue(lw7, 0, 0);
        issue(lw5, 0, 0);  issue(sw5, 0, 0);  issue(sw5, 0, 0);
        issue(lw5, 0, 0);  issue(add65, 1, 1);
        issue(add3, 0, 0);
        repeat (3) issue(lw5, 0, 1);
        issue(lw5, 0, 0);
        repeat (5) begin
            issue(lw5, 0, 0); issue(add65, 0, 0); issue(add65, 0, 0);
        end
        drain();
        check("sat_cnt", 160'(bus.bubble_cnt_o), 160'(CNT_MAX));

        async_reset_check();

        // Random traffic; while stalled the front end re-presents the same instruction
        cur = add3;
        for (int n = 0; n < 1500; n++) begin
            if (!last_stall) begin
                cur = mk(ops[$urandom_range(0, 6)], 2'($urandom), 3'($urandom),
                         3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom, $urandom, $urandom);
                cur.m[0] = ($urandom_range(0, 9) < 4);
            end
            issue(cur, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end
        issue(lw5, 0, 0);
        issue(add3, 0, 0);
        async_reset_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
